// File: rtl/onehot_serializer.sv
// rtl/onehot_serializer.sv - splits a multi-hot request vector into one-hot beats, lowest index first
module onehot_serializer #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_onehot,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] zero_cnt
);

  localparam logic [N-1:0]     ONE_N   = N'(1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t       state;
  logic [N-1:0] pending;
  logic [N-1:0] pending_rest;

  function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] v);
    return v & (~v + ONE_N);
  endfunction

  function automatic logic single_bit(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - ONE_N)) == '0);
  endfunction

  // Bits still owed after the beat currently on out_onehot is taken.
  assign pending_rest = pending & ~out_onehot;

  // Every output is registered, so nothing on in_* reaches out_* in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
      zero_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_req != '0) begin
              state      <= SERVE;
              pending    <= in_req;
              out_valid  <= 1'b1;
              out_onehot <= lowest_bit(in_req);
              out_last   <= single_bit(in_req);
              busy       <= 1'b1;
              in_ready   <= 1'b0;
            end else if (zero_cnt != CNT_MAX) begin
              zero_cnt <= zero_cnt + ONE_C;
            end
          end
        end
        SERVE: begin
          if (out_ready) begin
            if (out_last) begin
              state      <= IDLE;
              pending    <= '0;
              out_valid  <= 1'b0;
              out_onehot <= '0;
              out_last   <= 1'b0;
              busy       <= 1'b0;
              in_ready   <= 1'b1;
            end else begin
              pending    <= pending_rest;
              out_onehot <= lowest_bit(pending_rest);
              out_last   <= single_bit(pending_rest);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_serializer.sv
// tb/tb_onehot_serializer.sv - directed self-checking bench for onehot_serializer
module tb_onehot_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_req = 4'b0000;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_last, busy;
  logic [3:0] out_onehot;
  logic [7:0] zero_cnt;

  logic       in_ready_b, out_valid_b, out_last_b, busy_b;
  logic [3:0] out_onehot_b;
  logic [1:0] zero_cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  onehot_serializer #(.N(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_req(in_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
    .out_last(out_last), .busy(busy), .zero_cnt(zero_cnt)
  );

  onehot_serializer #(.N(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_req(in_req),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_onehot(out_onehot_b),
    .out_last(out_last_b), .busy(busy_b), .zero_cnt(zero_cnt_b)
  );

  function automatic logic [1:0] enc42(input logic [3:0] v);
    case (v)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Beat shape must hold every cycle, independent of which scenario is running.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (out_valid && $countones(out_onehot) != 1) begin
        errors++;
        $display("FAIL onehot_shape: out_onehot=%b with out_valid=1, required exactly one bit", out_onehot);
      end else if (!out_valid && out_onehot != 4'b0000) begin
        errors++;
        $display("FAIL idle_zero: out_onehot=%b with out_valid=0, required 0000", out_onehot);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_onehot, out_last, busy, in_ready} !== {1'b0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b oh=%b last=%b busy=%b rdy=%b, required 0 0000 0 0 1",
               out_valid, out_onehot, out_last, busy, in_ready);
    end
    checks++;
    if (zero_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_zero_cnt: got %0d, required 0", zero_cnt);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_req = 4'b0100; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_onehot, out_last, busy, in_ready} !== {1'b1, 4'b0100, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_beat: got v=%b oh=%b last=%b busy=%b rdy=%b, required 1 0100 1 1 0",
               out_valid, out_onehot, out_last, busy, in_ready);
    end
    checks++;
    if (enc42(out_onehot) !== 2'b10) begin
      errors++;
      $display("FAIL single_enc: got y=%b, required 10", enc42(out_onehot));
    end
    tick();
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL single_idle: got v=%b busy=%b rdy=%b, required 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_multi();
    logic [3:0] exp_beat [3] = '{4'b0001, 4'b0010, 4'b1000};
    logic       exp_last [3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0] exp_y    [3] = '{2'b00, 2'b01, 2'b11};
    in_valid = 1'b1; in_req = 4'b1011; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, out_onehot, out_last} !== {1'b1, exp_beat[i], exp_last[i]}) begin
        errors++;
        $display("FAIL multi_beat%0d: got v=%b oh=%b last=%b, required 1 %b %b",
                 i, out_valid, out_onehot, out_last, exp_beat[i], exp_last[i]);
      end
      checks++;
      if (enc42(out_onehot) !== exp_y[i]) begin
        errors++;
        $display("FAIL multi_enc%0d: got y=%b, required %b", i, enc42(out_onehot), exp_y[i]);
      end
      tick();
    end
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL multi_done: got v=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_req = 4'b1101; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_onehot, out_last} !== {1'b1, 4'b0001, 1'b0}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got v=%b oh=%b last=%b, required 1 0001 0",
                 i, out_valid, out_onehot, out_last);
      end
      if (i == 3) out_ready = 1'b1;
      tick();
    end
    checks++;
    if ({out_onehot, out_last} !== {4'b0100, 1'b0}) begin
      errors++;
      $display("FAIL hold_beat1: got oh=%b last=%b, required 0100 0", out_onehot, out_last);
    end
    tick();
    checks++;
    if ({out_onehot, out_last} !== {4'b1000, 1'b1}) begin
      errors++;
      $display("FAIL hold_beat2: got oh=%b last=%b, required 1000 1", out_onehot, out_last);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_done: got v=%b, required 0", out_valid);
    end
  endtask

  task automatic test_ignore_in_serve();
    in_valid = 1'b1; in_req = 4'b0011; out_ready = 1'b0;
    tick();
    in_req = 4'b1111;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL serve_in_ready: got %b, required 0", in_ready);
    end
    tick();
    out_ready = 1'b1;
    checks++;
    if ({out_onehot, out_last} !== {4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL serve_beat0: got oh=%b last=%b, required 0001 0", out_onehot, out_last);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_onehot, out_last} !== {4'b0010, 1'b1}) begin
      errors++;
      $display("FAIL serve_beat1: got oh=%b last=%b, required 0010 1", out_onehot, out_last);
    end
    tick(); tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL serve_ignored: got v=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero_vectors();
    in_valid = 1'b1; in_req = 4'b0000; out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL zero_idle%0d: got v=%b rdy=%b, required 0 1", i, out_valid, in_ready);
      end
      checks++;
      if (zero_cnt !== 8'(i)) begin
        errors++;
        $display("FAIL zero_cnt%0d: got %0d, required %0d", i, zero_cnt, i);
      end
      checks++;
      if (zero_cnt_b !== ((i > 3) ? 2'd3 : 2'(i))) begin
        errors++;
        $display("FAIL zero_sat%0d: got %0d, required %0d", i, zero_cnt_b, (i > 3) ? 3 : i);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_req = 4'b1111; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_onehot !== 4'b0001) begin
      errors++;
      $display("FAIL mid_beat0: got %b, required 0001", out_onehot);
    end
    tick();
    checks++;
    if (out_onehot !== 4'b0010) begin
      errors++;
      $display("FAIL mid_beat1: got %b, required 0010", out_onehot);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_onehot, busy, in_ready} !== {1'b0, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset: got v=%b oh=%b busy=%b rdy=%b, required 0 0000 0 1",
               out_valid, out_onehot, busy, in_ready);
    end
    checks++;
    if (zero_cnt !== 8'd0 || zero_cnt_b !== 2'd0) begin
      errors++;
      $display("FAIL mid_zero_cnt: got %0d/%0d, required 0/0", zero_cnt, zero_cnt_b);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_beat%0d: got v=%b oh=%b, required v=0", i, out_valid, out_onehot);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_ignore_in_serve();
    test_zero_vectors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
